escaner_anillo: RTL

//  Parametrised ring scanner for multiplexed 7-segment displays. It drives N

---
 rtl/escaner_anillo_pkg.sv | 47 ++++
 rtl/escaner_anillo_if.sv | 27 ++
 rtl/escaner_anillo_divisor_tick.sv | 36 +++
 rtl/escaner_anillo.sv | 88 ++++++++
 4 files changed

// File: rtl/escaner_anillo_pkg.sv
// Shared helpers for the display ring scanner: width math, anode levels and
// the circular search for the next enabled digit.
package escaner_anillo_pkg;

  localparam int MAX_DIGITS = 32;

  typedef struct packed {
    logic        found;
    logic        wrap;
    logic [31:0] idx;
  } next_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic anode_level(input logic act_low, input logic on);
    return on ^ act_low;
  endfunction

  // Walks downwards so the last hit written is the nearest one after sel.
  function automatic next_t next_enabled(input int sel,
                                         input logic [MAX_DIGITS-1:0] mask,
                                         input int n);
    next_t r;
    int    i;
    r = '0;
    for (int k = MAX_DIGITS; k >= 1; k--) begin
      if (k <= n) begin
        i = sel + k;
        if (i >= n) i = i - n;
        if (mask[i[4:0]]) begin
          r.found = 1'b1;
          r.wrap  = (i <= sel);
          r.idx   = i;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/escaner_anillo_if.sv
// Control inputs and display outputs of the ring scanner, bundled as one bus.
interface escaner_anillo_if
  import escaner_anillo_pkg::*;
#(
  parameter int N_DIGITS = 4
);
  localparam int SEL_W = clog2(N_DIGITS);

  logic                i_Enable;
  logic                i_Mode;
  logic                i_Step;
  logic [N_DIGITS-1:0] i_DigitMask;
  logic [N_DIGITS-1:0] o_Anodos;
  logic [SEL_W-1:0]    o_Sel;
  logic                o_Blank;
  logic                o_FrameStart;

  modport master (
    output i_Enable, i_Mode, i_Step, i_DigitMask,
    input  o_Anodos, o_Sel, o_Blank, o_FrameStart
  );

  modport slave (
    input  i_Enable, i_Mode, i_Step, i_DigitMask,
    output o_Anodos, o_Sel, o_Blank, o_FrameStart
  );
endinterface

// File: rtl/escaner_anillo_divisor_tick.sv
// Slot counter: counts cycles within a digit slot, flags the last cycle of an
// auto slot and publishes the value the counter takes on the next edge.
module escaner_anillo_divisor_tick #(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int CNT_W     = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset_n,
  input  logic             i_Run,
  input  logic             i_Clear,
  input  logic             i_Sat,
  output logic [CNT_W-1:0] o_CntNext,
  output logic             o_Tick
);

  logic [CNT_W-1:0] r_Cnt;
  logic [CNT_W-1:0] w_CntNext;

  // Manual mode only needs to know the blanking window has elapsed, so the
  // count stops there instead of running towards the auto terminal value.
  always_comb begin
    w_CntNext = r_Cnt + CNT_W'(1);
    if (!i_Run || i_Clear)                           w_CntNext = '0;
    else if (i_Sat && r_Cnt >= CNT_W'(BLANK_CYC))    w_CntNext = r_Cnt;
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) r_Cnt <= '0;
    else            r_Cnt <= w_CntNext;
  end

  assign o_CntNext = w_CntNext;
  assign o_Tick    = (r_Cnt == CNT_W'(PRESCALE - 1));

endmodule

// File: rtl/escaner_anillo.sv
// Ring scanner for multiplexed 7-segment displays: rotates a one-hot anode over
// the enabled digits with prescaled or stepped refresh and anti-ghost blanking.
module escaner_anillo
  import escaner_anillo_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int PRESCALE      = 50000,
  parameter int BLANK_CYC     = 16,
  parameter bit ANODE_ACT_LOW = 1'b1
) (
  input logic              i_Clk,
  input logic              i_Reset_n,
  escaner_anillo_if.slave  io_Bus
);

  localparam int   SEL_W  = clog2(N_DIGITS);
  localparam int   CNT_W  = clog2(PRESCALE);
  localparam logic A_ON   = anode_level(ANODE_ACT_LOW, 1'b1);
  localparam logic A_OFF  = anode_level(ANODE_ACT_LOW, 1'b0);

  logic                r_FrameStart;
  logic                r_Blank;
  logic [SEL_W-1:0]    r_Sel;
  logic [N_DIGITS-1:0] r_Anodos;

  logic                w_Tick;
  logic                w_Adv;
  logic                w_Upd;
  logic                w_Lit;
  logic [CNT_W-1:0]    w_CntNext;
  logic [SEL_W-1:0]    w_NextSel;
  logic [SEL_W-1:0]    w_SelNext;
  next_t               w_Next;

  assign w_Adv = io_Bus.i_Enable & (io_Bus.i_Mode ? io_Bus.i_Step : w_Tick);

  escaner_anillo_divisor_tick #(
    .PRESCALE  (PRESCALE),
    .BLANK_CYC (BLANK_CYC),
    .CNT_W     (CNT_W)
  ) u_divisor (
    .i_Clk     (i_Clk),
    .i_Reset_n (i_Reset_n),
    .i_Run     (io_Bus.i_Enable),
    .i_Clear   (w_Adv),
    .i_Sat     (io_Bus.i_Mode),
    .o_CntNext (w_CntNext),
    .o_Tick    (w_Tick)
  );

  always_comb begin
    w_Next    = next_enabled(int'(r_Sel), 32'(io_Bus.i_DigitMask), N_DIGITS);
    w_NextSel = r_Sel;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (w_Next.idx == j) w_NextSel = j[SEL_W-1:0];
    end
  end

  assign w_Upd     = w_Adv & w_Next.found;
  assign w_SelNext = w_Upd ? w_NextSel : r_Sel;

  // Lit is judged on the values the registers are about to take, so the
  // anode never shows the old digit while o_Sel already names the new one.
  assign w_Lit = io_Bus.i_Enable & io_Bus.i_DigitMask[w_SelNext] &
                 (w_CntNext >= CNT_W'(BLANK_CYC));

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Sel        <= '0;
      r_FrameStart <= 1'b0;
      r_Blank      <= 1'b1;
      r_Anodos     <= {N_DIGITS{A_OFF}};
    end else begin
      r_Sel        <= w_SelNext;
      r_FrameStart <= w_Upd & w_Next.wrap;
      r_Blank      <= ~w_Lit;
      for (int j = 0; j < N_DIGITS; j++) begin
        r_Anodos[j] <= (w_Lit && (w_SelNext == j[SEL_W-1:0])) ? A_ON : A_OFF;
      end
    end
  end

  assign io_Bus.o_Sel        = r_Sel;
  assign io_Bus.o_FrameStart = r_FrameStart;
  assign io_Bus.o_Blank      = r_Blank;
  assign io_Bus.o_Anodos     = r_Anodos;

endmodule
